ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_if.sv | 13 +
 rtl/ram_ctrl.sv | 107 ++++++++++
 tb/tb_ram_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: four-phase handshake bus between an initiator and ram_ctrl.
interface ram_ctrl_if;
  logic        ram_txs;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [63:0] ram_addr;
  logic        ram_txe;
  logic        ram_err;
  logic [31:0] ram_out;
  modport master (output ram_txs, ram_re, ram_we, ram_wd, ram_addr, input ram_txe, ram_err, ram_out);
  modport slave (input ram_txs, ram_re, ram_we, ram_wd, ram_addr, output ram_txe, ram_err, ram_out);
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: word RAM behind a four-phase handshake; RAM_CTRL_LATENCY_EN enables LATENCY-cycle response.
module ram_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic       clk,
  input logic       rst,
  ram_ctrl_if.slave s
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic          we_q, we_d;
  logic          bad_q, bad_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wd_q, wd_d;
  logic          txe_q, txe_d;
  logic          err_q, err_d;
  logic [31:0]   out_q, out_d;
  logic          mem_wr, go;
  logic [31:0]   mem_q [DEPTH];
`ifdef RAM_CTRL_LATENCY_EN
  logic [7:0]    cnt_q, cnt_d;
`endif
  assign s.ram_txe = txe_q;
  assign s.ram_err = err_q;
  assign s.ram_out = out_q;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    txe_d   = txe_q;
    err_d   = err_q;
    out_d   = out_q;
    mem_wr  = 1'b0;
    go      = 1'b0;
`ifdef RAM_CTRL_LATENCY_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (s.ram_txs) begin
        state_d = BUSY;
        we_d    = s.ram_we;
        bad_d   = (s.ram_addr >= 64'(DEPTH)) || (s.ram_re == s.ram_we);
        idx_d   = s.ram_addr[AW-1:0];
        wd_d    = s.ram_wd;
`ifdef RAM_CTRL_LATENCY_EN
        cnt_d   = 8'(LATENCY - 1);
`endif
      end
      BUSY: begin
`ifdef RAM_CTRL_LATENCY_EN
        go    = cnt_q == 8'd0;
        cnt_d = go ? cnt_q : cnt_q - 8'd1;
`else
        go    = 1'b1;
`endif
        if (go) begin
          state_d = DONE;
          txe_d   = 1'b1;
          err_d   = bad_q;
          out_d   = bad_q ? 32'd0 : (we_q ? out_q : mem_q[idx_q]);
          mem_wr  = !bad_q && we_q;
        end
      end
      DONE: if (!s.ram_txs) begin
        state_d = IDLE;
        txe_d   = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      txe_q   <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
`ifdef RAM_CTRL_LATENCY_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      txe_q   <= txe_d;
      err_q   <= err_d;
      out_q   <= out_d;
`ifdef RAM_CTRL_LATENCY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  // Reset at the DONE-entry edge must also suppress the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) mem_q[idx_q] <= wd_q;
  end
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed self-checking bench for ram_ctrl (DEPTH=256, LATENCY=4).
module tb_ram_ctrl;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
`ifdef RAM_CTRL_LATENCY_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 1;
`endif
  ram_ctrl_if bus ();
  ram_ctrl #(.DEPTH(256), .LATENCY(4)) dut (.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_txe(input string tag);
    int n = 0;
    while (!bus.ram_txe && n < 40) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(EXP_LAT));
  endtask
  task automatic do_tx(input logic re, input logic we, input logic [63:0] a, input logic [31:0] d,
                       output logic [31:0] o, output logic e);
    bus.ram_re = re;
    bus.ram_we = we;
    bus.ram_addr = a;
    bus.ram_wd = d;
    bus.ram_txs = 1'b1;
    tick();
    bus.ram_re = ~re;
    bus.ram_we = ~we;
    bus.ram_addr = a ^ 64'h1;
    bus.ram_wd = ~d;
    wait_txe("lat");
    check("txe_rise", bus.ram_txe, 1'b1);
    o = bus.ram_out;
    e = bus.ram_err;
    bus.ram_txs = 1'b0;
    tick();
    check("txe_fall", bus.ram_txe, 1'b0);
    check("err_fall", bus.ram_err, 1'b0);
    check("out_hold", bus.ram_out, o);
  endtask
  logic [31:0] o;
  logic e;
  initial begin
    rst = 1'b1;
    bus.ram_txs = 1'b0;
    bus.ram_re = 1'b0;
    bus.ram_we = 1'b0;
    bus.ram_wd = '0;
    bus.ram_addr = '0;
    tick();
    tick();
    check("rst_txe", bus.ram_txe, 1'b0);
    check("rst_err", bus.ram_err, 1'b0);
    check("rst_out", bus.ram_out, 32'd0);
    rst = 1'b0;
    tick();
    do_tx(1'b0, 1'b1, 64'd5, 32'hDEADBEEF, o, e);
    check("wr5_err", e, 1'b0);
    do_tx(1'b1, 1'b0, 64'd5, 32'h0, o, e);
    check("rd5_out", o, 32'hDEADBEEF);
    check("rd5_err", e, 1'b0);
    do_tx(1'b0, 1'b1, 64'd0, 32'hA5A5_0000, o, e);
    check("wr_keeps_out", o, 32'hDEADBEEF);
    do_tx(1'b1, 1'b0, 64'd256, 32'h0, o, e);
    check("oob_err", e, 1'b1);
    check("oob_out", o, 32'd0);
    do_tx(1'b1, 1'b0, 64'h1_0000_0000, 32'h0, o, e);
    check("oob_hi_err", e, 1'b1);
    do_tx(1'b1, 1'b0, 64'd0, 32'h0, o, e);
    check("rd0_out", o, 32'hA5A5_0000);
    do_tx(1'b0, 1'b1, 64'd3, 32'h3333_3333, o, e);
    do_tx(1'b1, 1'b1, 64'd3, 32'hBAD0_BAD0, o, e);
    check("rewe_err", e, 1'b1);
    check("rewe_out", o, 32'd0);
    do_tx(1'b0, 1'b0, 64'd3, 32'hBAD1_BAD1, o, e);
    check("none_err", e, 1'b1);
    do_tx(1'b1, 1'b0, 64'd3, 32'h0, o, e);
    check("rd3_out", o, 32'h3333_3333);
    check("rd3_err", e, 1'b0);
    // Hold txs through DONE while changing inputs: exactly one write must land.
    bus.ram_re = 1'b0;
    bus.ram_we = 1'b1;
    bus.ram_addr = 64'd9;
    bus.ram_wd = 32'd1;
    bus.ram_txs = 1'b1;
    tick();
    wait_txe("hold_lat");
    for (int i = 0; i < 10; i++) begin
      bus.ram_wd = 32'(i + 100);
      bus.ram_addr = 64'd9;
      tick();
      check("hold_txe", bus.ram_txe, 1'b1);
    end
    bus.ram_txs = 1'b0;
    tick();
    check("hold_drop_txe", bus.ram_txe, 1'b0);
    check("hold_drop_err", bus.ram_err, 1'b0);
    do_tx(1'b1, 1'b0, 64'd9, 32'h0, o, e);
    check("rd9_out", o, 32'd1);
    // txs dropped right after capture still completes the access.
    bus.ram_re = 1'b0;
    bus.ram_we = 1'b1;
    bus.ram_addr = 64'd10;
    bus.ram_wd = 32'hAB;
    bus.ram_txs = 1'b1;
    tick();
    bus.ram_txs = 1'b0;
    wait_txe("early_drop_lat");
    tick();
    check("early_drop_txe", bus.ram_txe, 1'b0);
    do_tx(1'b1, 1'b0, 64'd10, 32'h0, o, e);
    check("rd10_out", o, 32'hAB);
    do_tx(1'b0, 1'b1, 64'd7, 32'h1111_1111, o, e);
    bus.ram_re = 1'b0;
    bus.ram_we = 1'b1;
    bus.ram_addr = 64'd7;
    bus.ram_wd = 32'h12345678;
    bus.ram_txs = 1'b1;
    tick();
    rst = 1'b1;
    bus.ram_txs = 1'b0;
    tick();
    check("rst_busy_txe", bus.ram_txe, 1'b0);
    check("rst_busy_out", bus.ram_out, 32'd0);
    rst = 1'b0;
    tick();
    do_tx(1'b1, 1'b0, 64'd7, 32'h0, o, e);
    check("rd7_out", o, 32'h1111_1111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
